muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide sequencer. It time-shares one instance of the team's 32-bit CLA adder (cla32).
//  - Adder port A is driven from the sequencer's operand mux. Its carry-out port (OF) is used as the carry/no-borrow flag.
//  - Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU by shift-add and restoring shift-subtract.
//  - Sits beside the ALU in EX; the core stalls on BUSY.
// PARAMETERS
//  XLEN   32  operand/result width (only 32 supported; adder is fixed 32-bit)
//  ITERS  32  CALC iterations (= XLEN)
// PORTS
//  CLK     in   1   clock, rising edge
//  RSTN    in   1   asynchronous, active-low reset
//  START   in   1   request; sampled only when BUSY=0
//  FLUSH   in   1   synchronous abort (pipeline flush)
//  OP      in   3   RV32M funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  RS1     in   32  dividend / multiplicand
//  RS2     in   32  divisor / multiplier
//  BUSY    out  1   operation in flight (PREP_A..FIX_HI)
//  DONE    out  1   one-cycle pulse, RESULT valid
//  RESULT  out  32  result, held stable until next accepted START
// BEHAVIOUR
//  - Reset (RSTN=0, async): state=IDLE, BUSY=0, DONE=0, RESULT=0, all working regs 0.
//  - State sequence: IDLE -> PREP_A -> PREP_B -> CALC x32 -> FIX_LO -> FIX_HI -> FIN -> IDLE.
//  - START is accepted in IDLE or FIN. OP/RS1/RS2 are latched in that cycle.
//  - START while BUSY=1 is ignored. DONE (FIN) rises exactly 37 cycles after the accepting edge, for every OP.
//  - Back-to-back: START in the FIN cycle is accepted and the DONE pulse still occurs.
//  - FLUSH: state->IDLE at the next edge, BUSY=0, no DONE, RESULT unchanged. FLUSH wins over a simultaneous START.
//  - Signedness: rs1 is signed for MULH, MULHSU, DIV, REM; rs2 is signed for MULH, DIV, REM.
//  - PREP_A: adder computes |RS1| as A=~RS1, B=0, CIN=1 if signed and negative, else the value passes through.
//  - PREP_B: computes |RS2| the same way.
//  - Sign flags are recorded:
//      - multiply: neg = sa^sb
//      - quotient: neg = sa^sb
//      - remainder: neg = sa
//  - CALC multiply: ACC(hi32):MQ(lo32), MQ=|rs1|.
//      - If MQ[0]=1, A=ACC, B=|rs2|, CIN=0.
//      - {COUT,SUM,MQ} >> 1 -> ACC:MQ; otherwise {0,ACC,MQ} >> 1.
//  - CALC divide: R(32):Q(32), Q=|rs1|, R=0.
//      - Shift {R,Q} left 1; msb = bit shifted out of R.
//      - Trial: A=R', B=~|rs2|, CIN=1.
//      - If COUT|msb, then R=SUM and Q[0]=1; else R unchanged and Q[0]=0.
//  - FIX_LO, when neg: lo = ~lo + 1 via adder; the carry is latched.
//  - FIX_HI, when neg: hi = ~hi + carry. Both are no-ops when neg=0.
//  - Divide-by-zero (rs2==0): neg is forced 0 for the quotient, giving Q=0xFFFFFFFF. REM/REMU return the original RS1 unmodified.
//  - Overflow (DIV 0x80000000 / 0xFFFFFFFF) falls out naturally: Q=0x80000000, R=0. No special case.
//  - RESULT select:
//      - MUL: lo
//      - MULH, MULHSU, MULHU: hi
//      - DIV, DIVU: Q
//      - REM, REMU: R
//  - RESULT registered on entry to FIN.
//  - Adder port mux is a function of state only. In IDLE/FIN: A=0, B=0, CIN=0.
// CONFIGURATION
//  - MULDIV_FASTPATH_EN defined: when accepted START has divisor==0 (DIV*/REM*) or either multiply operand==0 (MUL*):
//      - skip straight to FIN.
//      - DONE 2 cycles after the accepting edge.
//      - RESULT per RISC-V spec (0xFFFFFFFF / RS1 / 0).
//  - Undefined: every OP takes the fixed 37-cycle path. Results are identical either way.
// STRUCTURE
//  - muldiv_pkg: OP funct3 localparams, state encoding (IDLE,PREP_A,PREP_B,CALC,FIX_LO,FIX_HI,FIN), ITERS, LATENCY=37.
//  - Single sub-module: the existing cla32 instance. Control, operand mux and the 6-bit iteration counter stay in muldiv_seq.
// TESTING
//  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> RESULT 0xFFFFFFFE; MUL same operands -> 0x00000001; DONE at cycle 37.
//  - MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  - DIV 5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  - START at cycle 10 while BUSY ignored; FLUSH at CALC iter 5 -> BUSY=0 next cycle, no DONE, RESULT unchanged.
//  - RSTN low mid-CALC -> outputs 0 immediately. START in FIN cycle -> next DONE 37 cycles later.
//    With MULDIV_FASTPATH_EN: DIVU x/0 -> DONE 2 cycles after the accepting edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_pkg : shared constants for the RV32M multiply/divide sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package muldiv_pkg;

  localparam int ITERS   = 32;
  localparam int LATENCY = 37;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PREP_A = 3'd1;
  localparam logic [2:0] ST_PREP_B = 3'd2;
  localparam logic [2:0] ST_CALC   = 3'd3;
  localparam logic [2:0] ST_FIX_LO = 3'd4;
  localparam logic [2:0] ST_FIX_HI = 3'd5;
  localparam logic [2:0] ST_FIN    = 3'd6;

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla32 : 32-bit carry-lookahead adder, 4-bit lookahead groups         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cla32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        of_o
);

  logic [31:0] w_p;
  logic [31:0] w_g;
  logic [31:0] w_c;
  logic [8:0]  w_gc;

  assign w_p     = a_i ^ b_i;
  assign w_g     = a_i & b_i;
  assign w_gc[0] = cin_i;

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int BASE = 4 * gi;
    logic [3:0] p;
    logic [3:0] g;
    logic       c0;

    assign p  = w_p[BASE+3:BASE];
    assign g  = w_g[BASE+3:BASE];
    assign c0 = w_gc[gi];

    assign w_c[BASE]   = c0;
    assign w_c[BASE+1] = g[0] | (p[0] & c0);
    assign w_c[BASE+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign w_c[BASE+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                       | (p[2] & p[1] & p[0] & c0);
    assign w_gc[gi+1]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c0);
  end

  assign sum_o = w_p ^ w_c;
  assign of_o  = w_gc[8];

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_seq : iterative RV32M mul/div sequencer sharing one cla32     |
// | Option macro: MULDIV_FASTPATH_EN (zero-operand early finish)         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mq_q, mq_d;
  logic [XLEN-1:0] bop_q, bop_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            sa_q, sa_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;
  logic            carry_q, carry_d;
  logic [5:0]      cnt_q, cnt_d;

  logic [XLEN-1:0] w_add_a;
  logic [XLEN-1:0] w_add_b;
  logic [XLEN-1:0] w_add_sum;
  logic            w_add_cin;
  logic            w_add_cout;
  logic            w_sa;
  logic            w_sb;

  assign w_sa = rs1_signed(op_q) & rs1_q[XLEN-1];
  assign w_sb = rs2_signed(op_q) & rs2_q[XLEN-1];

`ifdef MULDIV_FASTPATH_EN
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;
  assign w_fast     = is_div(op_q) ? (rs2_q == '0) : ((rs1_q == '0) || (rs2_q == '0));
  assign w_fast_res = !is_div(op_q) ? '0 : (is_rem(op_q) ? rs1_q : '1);
`endif

  // Operand mux: a negate is ~x + 1, a pass-through is x + 0 + 0.
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    case (state_q)
      ST_PREP_A: begin
        w_add_a   = w_sa ? ~rs1_q : rs1_q;
        w_add_cin = w_sa;
      end
      ST_PREP_B: begin
        w_add_a   = w_sb ? ~rs2_q : rs2_q;
        w_add_cin = w_sb;
      end
      ST_CALC: begin
        if (is_div(op_q)) begin
          w_add_a   = {acc_q[XLEN-2:0], mq_q[XLEN-1]};
          w_add_b   = ~bop_q;
          w_add_cin = 1'b1;
        end else begin
          w_add_a   = acc_q;
          w_add_b   = bop_q;
        end
      end
      ST_FIX_LO: begin
        w_add_a   = neg_lo_q ? ~mq_q : mq_q;
        w_add_cin = neg_lo_q;
      end
      ST_FIX_HI: begin
        w_add_a   = neg_hi_q ? ~acc_q : acc_q;
        w_add_cin = neg_hi_q & carry_q;
      end
      default: ;
    endcase
  end

  cla32 u_cla32 (
    .a_i   (w_add_a),
    .b_i   (w_add_b),
    .cin_i (w_add_cin),
    .sum_o (w_add_sum),
    .of_o  (w_add_cout)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    bop_d    = bop_q;
    result_d = result_q;
    sa_d     = sa_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;

    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_FIN: begin
          state_d = ST_IDLE;
          if (start_i) begin
            state_d = ST_PREP_A;
            op_d    = op_i;
            rs1_d   = rs1_i;
            rs2_d   = rs2_i;
          end
        end
        ST_PREP_A: begin
          mq_d    = w_add_sum;
          acc_d   = '0;
          sa_d    = w_sa;
          state_d = ST_PREP_B;
`ifdef MULDIV_FASTPATH_EN
          if (w_fast) begin
            state_d  = ST_FIN;
            result_d = w_fast_res;
          end
`endif
        end
        ST_PREP_B: begin
          bop_d   = w_add_sum;
          cnt_d   = 6'(ITERS - 1);
          state_d = ST_CALC;
          // Lo holds the quotient, hi the remainder; only one of them is fixed for divides.
          if (!is_div(op_q)) begin
            neg_lo_d = sa_q ^ w_sb;
            neg_hi_d = sa_q ^ w_sb;
          end else if (!is_rem(op_q)) begin
            neg_lo_d = (sa_q ^ w_sb) & (rs2_q != '0);
            neg_hi_d = 1'b0;
          end else begin
            neg_lo_d = 1'b0;
            neg_hi_d = sa_q;
          end
        end
        ST_CALC: begin
          if (is_div(op_q)) begin
            if (w_add_cout | acc_q[XLEN-1]) begin
              acc_d = w_add_sum;
              mq_d  = {mq_q[XLEN-2:0], 1'b1};
            end else begin
              acc_d = {acc_q[XLEN-2:0], mq_q[XLEN-1]};
              mq_d  = {mq_q[XLEN-2:0], 1'b0};
            end
          end else if (mq_q[0]) begin
            acc_d = {w_add_cout, w_add_sum[XLEN-1:1]};
            mq_d  = {w_add_sum[0], mq_q[XLEN-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[XLEN-1:1]};
            mq_d  = {acc_q[0], mq_q[XLEN-1:1]};
          end
          if (cnt_q == '0) state_d = ST_FIX_LO;
          else             cnt_d   = cnt_q - 6'd1;
        end
        ST_FIX_LO: begin
          mq_d    = w_add_sum;
          // A lone remainder negate still needs the +1.
          carry_d = neg_lo_q ? w_add_cout : 1'b1;
          state_d = ST_FIX_HI;
        end
        ST_FIX_HI: begin
          acc_d   = w_add_sum;
          state_d = ST_FIN;
          if ((op_q == OP_MUL) || (is_div(op_q) && !is_rem(op_q))) result_d = mq_q;
          else                                                       result_d = w_add_sum;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      bop_q    <= '0;
      result_q <= '0;
      sa_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      bop_q    <= bop_d;
      result_q <= result_d;
      sa_q     <= sa_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done_o   = (state_q == ST_FIN);
  assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_seq : vector table, random ops vs arithmetic model, corners |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .start_i  (start),
    .flush_i  (flush),
    .op_i     (op),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Plain 64-bit / signed arithmetic, with the RISC-V rules for /0 and overflow.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    logic signed [31:0] a32, b32;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    a32 = a;
    b32 = b;
    case (f)
      OP_MUL:    begin p = ua * ub; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return a32 / b32;
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return a32 % b32;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
    if (f[2] ? (b == 0) : (a == 0 || b == 0)) return 2;
`endif
    return 37;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle n is the n-th negedge after the accepting edge; 0 means timed out.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_check(input string name, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    int n;
    issue(f, a, b);
    wait_done(n);
    check({name, " latency"}, 32'(n), 32'(exp_lat(f, a, b)));
    check({name, " result"}, result, exp);
  endtask

  initial begin
    int n, cnt;
    logic [2:0]  f;
    logic [31:0] a, b;

    vecs[0]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14};
    vecs[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2};
    vecs[8]  = '{OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    vecs[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{OP_DIVU,   32'd123,       32'd0,         32'hFFFF_FFFF};
    vecs[13] = '{OP_REMU,   32'd9,         32'd0,         32'd9};
    vecs[14] = '{OP_MUL,    32'd0,         32'd5,         32'd0};

    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++)
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // START at cycle 10 while busy must be dropped, not queued.
    issue(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 10) begin op = OP_DIVU; rs1 = 32'd77; rs2 = 32'd3; start = 1'b1; end
      if (i == 11) start = 1'b0;
      if (done) begin n = i; break; end
    end
    check("busy-start latency", 32'(n), 32'd37);
    check("busy-start result", result, 32'h0B00_EA4E);
    cnt = 0;
    repeat (45) begin @(negedge clk); if (done) cnt++; end
    check("busy-start no extra done", 32'(cnt), 32'd0);

    // FLUSH at CALC iteration 5 (cycle 8).
    run_check("pre-flush", OP_DIVU, 32'd100, 32'd7, 32'd14);
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    check("busy before flush", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    check("flush result held", result, 32'd14);
    cnt = 0;
    repeat (45) begin @(negedge clk); if (done) cnt++; end
    check("flush no done", 32'(cnt), 32'd0);
    @(negedge clk);
    op = OP_MUL; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    check("flush beats start", 32'(busy), 32'd0);

    // START in the FIN cycle is accepted.
    issue(OP_MULH, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    check("b2b first latency", 32'(n), 32'd37);
    check("b2b first result", result, 32'hFFFF_FFFF);
    op = OP_REM; rs1 = 32'd50; rs2 = 32'hFFFF_FFF9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    check("b2b second latency", 32'(n), 32'd37);
    check("b2b second result", result, 32'd1);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 7))
          0:       b = 32'd0;
          1:       b = 32'h8000_0000;
          2:       b = 32'hFFFF_FFFF;
          3:       b = 32'($urandom_range(0, 15));
          default: b = $urandom;
        endcase
        if (k == 0) a = b;
      end
      run_check($sformatf("rand%0d op%0d", i, f), f, a, b, ref_model(f, a, b));
    end

    // Async reset mid-CALC clears outputs without waiting for an edge.
    run_check("pre-reset", OP_DIVU, 32'd100, 32'd7, 32'd14);
    issue(OP_MULHU, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset result", result, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_check("post-reset", OP_MUL, 32'd6, 32'd7, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
